uart_cmd_sequencer: RTL and testbench



---
 rtl/uart_cmd_sequencer.sv | 149 ++++++++++++++
 tb/tb_uart_cmd_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer: turns UART bytes into 32-bit bus commands.
// Frames are an opcode byte followed by a big-endian address and, for writes,
// big-endian write data. One command at a time goes out on a valid/ready
// interface. A stalled frame is dropped after TIMEOUT_TICKS baud ticks without
// a byte. Protocol and overrun errors are reported as registered one-cycle pulses.
module uart_cmd_sequencer #(
    parameter int unsigned TIMEOUT_TICKS = 2048,
    parameter logic [7:0]  CMD_WR        = 8'h57,
    parameter logic [7:0]  CMD_RD        = 8'h52
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        b_tick,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_wr,
    output logic [31:0] cmd_addr,
    output logic [31:0] cmd_wdata,
    output logic        busy,
    output logic        frame_err,
    output logic        overrun
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        ISSUE
    } state_t;

    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_TICKS);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  byte_cnt;
    logic [1:0]  byte_cnt_nxt;
    logic [15:0] tmo_cnt;
    logic [15:0] tmo_nxt;
    logic        wr_nxt;
    logic [31:0] addr_nxt;
    logic [31:0] wdata_nxt;
    logic        ferr_nxt;
    logic        ovr_nxt;
    logic        take_opcode;

    // The command is presented only from ISSUE, so valid and busy decode straight from state.
    assign cmd_valid = (state == ISSUE);
    assign busy      = (state != IDLE);

    // Next-state and datapath logic. An opcode is accepted in IDLE and also in the
    // handshake cycle, so a back-to-back frame does not lose its first byte.
    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        tmo_nxt      = tmo_cnt;
        wr_nxt       = cmd_wr;
        addr_nxt     = cmd_addr;
        wdata_nxt    = cmd_wdata;
        ferr_nxt     = 1'b0;
        ovr_nxt      = 1'b0;
        take_opcode  = 1'b0;

        case (state)
            IDLE: begin
                take_opcode = rx_done;
            end
            ADDR, DATA: begin
                if (rx_done) begin
                    if (state == ADDR) begin
                        addr_nxt = {cmd_addr[23:0], rx_data};
                    end else begin
                        wdata_nxt = {cmd_wdata[23:0], rx_data};
                    end
                    byte_cnt_nxt = byte_cnt + 2'd1;
                    tmo_nxt      = '0;
                    if (byte_cnt == 2'd3) begin
                        if (state == ADDR && cmd_wr) begin
                            state_nxt = DATA;
                        end else begin
                            state_nxt = ISSUE;
                        end
                    end
                end else if (b_tick) begin
                    if (tmo_cnt + 16'd1 == TMO_LIMIT) begin
                        state_nxt = IDLE;
                        ferr_nxt  = 1'b1;
                        tmo_nxt   = '0;
                    end else begin
                        tmo_nxt = tmo_cnt + 16'd1;
                    end
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    state_nxt   = IDLE;
                    take_opcode = rx_done;
                end else if (rx_done) begin
                    ovr_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (take_opcode) begin
            if (rx_data == CMD_WR) begin
                wr_nxt       = 1'b1;
                state_nxt    = ADDR;
                byte_cnt_nxt = '0;
                tmo_nxt      = '0;
            end else if (rx_data == CMD_RD) begin
                wr_nxt       = 1'b0;
                wdata_nxt    = '0;
                state_nxt    = ADDR;
                byte_cnt_nxt = '0;
                tmo_nxt      = '0;
            end else begin
                ferr_nxt = 1'b1;
            end
        end
    end

    // State, command and counter registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            tmo_cnt   <= '0;
            cmd_wr    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            byte_cnt  <= byte_cnt_nxt;
            tmo_cnt   <= tmo_nxt;
            cmd_wr    <= wr_nxt;
            cmd_addr  <= addr_nxt;
            cmd_wdata <= wdata_nxt;
            frame_err <= ferr_nxt;
            overrun   <= ovr_nxt;
        end
    end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Testbench for uart_cmd_sequencer: directed vector table, hand-written corner
// sequences and random traffic, all compared against a frame-level reference model.
module tb_uart_cmd_sequencer;

    localparam int TMO = 32;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        b_tick = 1'b0;
    logic        rx_done = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        cmd_ready = 1'b0;
    logic        cmd_valid;
    logic        cmd_wr;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        busy;
    logic        frame_err;
    logic        overrun;

    int errors = 0;
    int checks = 0;

    uart_cmd_sequencer #(
        .TIMEOUT_TICKS(TMO),
        .CMD_WR(8'h57),
        .CMD_RD(8'h52)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .b_tick(b_tick),
        .rx_done(rx_done),
        .rx_data(rx_data),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .busy(busy),
        .frame_err(frame_err),
        .overrun(overrun)
    );

    // 100 MHz free-running clock.
    always #5 clk = ~clk;

    // Reference model: the bytes of the frame in progress, the pending command and
    // the number of baud ticks seen since the last byte.
    logic [7:0]  frame_q[$];
    bit          m_pend;
    logic        m_wr;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    int          m_ticks;
    bit          m_ferr;
    bit          m_ovr;

    function automatic void model_reset();
        frame_q.delete();
        m_pend  = 1'b0;
        m_wr    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_ticks = 0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
    endfunction

    function automatic void model_start(logic [7:0] b);
        if (b == 8'h57 || b == 8'h52) begin
            frame_q.delete();
            frame_q.push_back(b);
            m_ticks = 0;
        end else begin
            m_ferr = 1'b1;
        end
    endfunction

    function automatic void model_step();
        int need;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        if (m_pend) begin
            if (cmd_ready) begin
                m_pend = 1'b0;
                if (rx_done) model_start(rx_data);
            end else if (rx_done) begin
                m_ovr = 1'b1;
            end
        end else if (frame_q.size() == 0) begin
            if (rx_done) model_start(rx_data);
        end else if (rx_done) begin
            frame_q.push_back(rx_data);
            m_ticks = 0;
            need = (frame_q[0] == 8'h57) ? 9 : 5;
            if (frame_q.size() == need) begin
                m_wr   = (frame_q[0] == 8'h57);
                m_addr = {frame_q[1], frame_q[2], frame_q[3], frame_q[4]};
                if (m_wr) begin
                    m_wdata = {frame_q[5], frame_q[6], frame_q[7], frame_q[8]};
                end else begin
                    m_wdata = '0;
                end
                m_pend = 1'b1;
                frame_q.delete();
            end
        end else if (b_tick) begin
            m_ticks++;
            if (m_ticks == TMO) begin
                frame_q.delete();
                m_ferr  = 1'b1;
                m_ticks = 0;
            end
        end
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compares every DUT output against the reference model.
    task automatic check_output();
        check_val("cmd_valid", 32'(cmd_valid), 32'(m_pend));
        check_val("busy", 32'(busy), 32'(m_pend || frame_q.size() != 0));
        check_val("frame_err", 32'(frame_err), 32'(m_ferr));
        check_val("overrun", 32'(overrun), 32'(m_ovr));
        if (m_pend) begin
            check_val("cmd_wr", 32'(cmd_wr), 32'(m_wr));
            check_val("cmd_addr", cmd_addr, m_addr);
            check_val("cmd_wdata", cmd_wdata, m_wdata);
        end
    endtask

    // Drives one clock cycle of inputs, advances the model and checks after the edge.
    task automatic apply_stimulus(input logic rd, input logic [7:0] data, input logic tk, input logic rdy);
        rx_done   = rd;
        rx_data   = data;
        b_tick    = tk;
        cmd_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
        check_output();
        rx_done = 1'b0;
        b_tick  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic rdy);
        apply_stimulus(1'b1, b, 1'b0, rdy);
    endtask

    task automatic idle_cycles(input int n, input logic rdy);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 8'h00, 1'b0, rdy);
    endtask

    typedef struct {
        logic        rd;
        logic [7:0]  data;
        logic        e_valid;
        logic        e_busy;
        logic        e_ferr;
        logic        e_wr;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
    } vec_t;

    function automatic vec_t mk(logic rd, logic [7:0] data, logic ev, logic eb, logic ef,
                                logic ew, logic [31:0] ea, logic [31:0] ed);
        vec_t v;
        v.rd = rd; v.data = data; v.e_valid = ev; v.e_busy = eb; v.e_ferr = ef;
        v.e_wr = ew; v.e_addr = ea; v.e_wdata = ed;
        return v;
    endfunction

    vec_t vecs[18];

    initial begin
        // Directed table, cmd_ready held high: write frame, bad opcode, read frame.
        vecs[0]  = mk(1, 8'h57, 0, 1, 0, 0, 0, 0);
        vecs[1]  = mk(1, 8'h12, 0, 1, 0, 0, 0, 0);
        vecs[2]  = mk(1, 8'h34, 0, 1, 0, 0, 0, 0);
        vecs[3]  = mk(1, 8'h56, 0, 1, 0, 0, 0, 0);
        vecs[4]  = mk(1, 8'h78, 0, 1, 0, 0, 0, 0);
        vecs[5]  = mk(1, 8'hDE, 0, 1, 0, 0, 0, 0);
        vecs[6]  = mk(1, 8'hAD, 0, 1, 0, 0, 0, 0);
        vecs[7]  = mk(1, 8'hBE, 0, 1, 0, 0, 0, 0);
        vecs[8]  = mk(1, 8'hEF, 1, 1, 0, 1, 32'h12345678, 32'hDEADBEEF);
        vecs[9]  = mk(0, 8'h00, 0, 0, 0, 0, 0, 0);
        vecs[10] = mk(1, 8'h41, 0, 0, 1, 0, 0, 0);
        vecs[11] = mk(0, 8'h00, 0, 0, 0, 0, 0, 0);
        vecs[12] = mk(1, 8'h52, 0, 1, 0, 0, 0, 0);
        vecs[13] = mk(1, 8'h00, 0, 1, 0, 0, 0, 0);
        vecs[14] = mk(1, 8'h00, 0, 1, 0, 0, 0, 0);
        vecs[15] = mk(1, 8'h10, 0, 1, 0, 0, 0, 0);
        vecs[16] = mk(1, 8'h04, 1, 1, 0, 0, 32'h00001004, 32'h0);
        vecs[17] = mk(0, 8'h00, 0, 0, 0, 0, 0, 0);

        // Reset values.
        model_reset();
        #1;
        check_val("rst_valid", 32'(cmd_valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_addr", cmd_addr, 32'd0);
        check_val("rst_wdata", cmd_wdata, 32'd0);
        check_val("rst_wr", 32'(cmd_wr), 32'd0);
        check_val("rst_ferr", 32'(frame_err), 32'd0);
        check_val("rst_ovr", 32'(overrun), 32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        for (int i = 0; i < 18; i++) begin
            apply_stimulus(vecs[i].rd, vecs[i].data, 1'b0, 1'b1);
            check_val($sformatf("vec%0d_valid", i), 32'(cmd_valid), 32'(vecs[i].e_valid));
            check_val($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check_val($sformatf("vec%0d_ferr", i), 32'(frame_err), 32'(vecs[i].e_ferr));
            check_val($sformatf("vec%0d_ovr", i), 32'(overrun), 32'd0);
            if (vecs[i].e_valid) begin
                check_val($sformatf("vec%0d_wr", i), 32'(cmd_wr), 32'(vecs[i].e_wr));
                check_val($sformatf("vec%0d_addr", i), cmd_addr, vecs[i].e_addr);
                check_val($sformatf("vec%0d_wdata", i), cmd_wdata, vecs[i].e_wdata);
            end
        end

        // Read held by cmd_ready=0 for 20 cycles, then a single-cycle handshake.
        send_byte(8'h52, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h10, 0); send_byte(8'h04, 0);
        idle_cycles(20, 0);
        check_val("hold_valid", 32'(cmd_valid), 32'd1);
        check_val("hold_addr", cmd_addr, 32'h00001004);
        check_val("hold_wdata", cmd_wdata, 32'h0);
        check_val("hold_wr", 32'(cmd_wr), 32'd0);
        idle_cycles(1, 1);
        check_val("hold_release", 32'(cmd_valid), 32'd0);

        // Timeout: 32nd tick after the last byte abandons the frame.
        send_byte(8'h57, 0); send_byte(8'hAA, 0);
        for (int i = 0; i < TMO - 1; i++) apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
        check_val("tmo_early_ferr", 32'(frame_err), 32'd0);
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
        check_val("tmo_ferr", 32'(frame_err), 32'd1);
        check_val("tmo_busy", 32'(busy), 32'd0);
        idle_cycles(1, 0);

        // A byte on the terminal tick wins; the frame then completes.
        send_byte(8'h57, 0); send_byte(8'hAA, 0);
        for (int i = 0; i < TMO - 1; i++) apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
        apply_stimulus(1'b1, 8'h11, 1'b1, 1'b0);
        check_val("tmo_race_ferr", 32'(frame_err), 32'd0);
        check_val("tmo_race_busy", 32'(busy), 32'd1);
        send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
        send_byte(8'h55, 0); send_byte(8'h66, 0); send_byte(8'h77, 0);
        check_val("tmo_race_addr", cmd_addr, 32'hAA112233);
        check_val("tmo_race_wdata", cmd_wdata, 32'h44556677);
        idle_cycles(1, 1);

        // Overrun while pending, then an opcode in the handshake cycle.
        send_byte(8'h52, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h00, 0); send_byte(8'h08, 0);
        send_byte(8'h55, 0);
        check_val("ovr_pulse", 32'(overrun), 32'd1);
        check_val("ovr_valid", 32'(cmd_valid), 32'd1);
        check_val("ovr_addr", cmd_addr, 32'h00000008);
        idle_cycles(1, 0);
        check_val("ovr_single", 32'(overrun), 32'd0);
        send_byte(8'h57, 1);
        check_val("hs_opc_ovr", 32'(overrun), 32'd0);
        check_val("hs_opc_valid", 32'(cmd_valid), 32'd0);
        check_val("hs_opc_busy", 32'(busy), 32'd1);
        send_byte(8'hCA, 1); send_byte(8'hFE, 1); send_byte(8'h00, 1); send_byte(8'h01, 1);
        send_byte(8'h01, 1); send_byte(8'h02, 1); send_byte(8'h03, 1); send_byte(8'h04, 1);
        idle_cycles(1, 1);

        // Asynchronous reset in the middle of a write frame.
        send_byte(8'h57, 0); send_byte(8'h01, 0); send_byte(8'h02, 0);
        #2 resetn = 1'b0;
        model_reset();
        #1;
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_valid", 32'(cmd_valid), 32'd0);
        check_val("mid_rst_addr", cmd_addr, 32'd0);
        check_val("mid_rst_wr", 32'(cmd_wr), 32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        send_byte(8'h57, 1); send_byte(8'h0A, 1); send_byte(8'h0B, 1); send_byte(8'h0C, 1);
        send_byte(8'h0D, 1); send_byte(8'h90, 1); send_byte(8'h91, 1); send_byte(8'h92, 1);
        send_byte(8'h93, 1);
        check_val("post_rst_addr", cmd_addr, 32'h0A0B0C0D);
        check_val("post_rst_wdata", cmd_wdata, 32'h90919293);
        idle_cycles(1, 1);

        // Random traffic with periodic quiet stretches to provoke timeouts.
        for (int i = 0; i < 3000; i++) begin
            logic       rd;
            logic [7:0] data;
            int         r;
            rd = ($urandom_range(0, 2) == 0) && ((i % 400) < 330);
            r  = int'($urandom_range(0, 9));
            if (r < 3) data = 8'h57;
            else if (r < 5) data = 8'h52;
            else data = 8'($urandom_range(0, 255));
            apply_stimulus(rd, data, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
